// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer.
package booth_pkg;

    localparam int N_DEFAULT = 5;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/booth_step_counter.sv
// Booth step counter: cleared on load, advanced once per shift, flags the final step.
module booth_step_counter
    import booth_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    logic [CW-1:0] count;

    // Saturates at N-1 so the count can never wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// LOAD  | load operands, clear accumulator and Booth flip-flop, clear step count
// EVAL  | add/subtract multiplicand according to Booth pair {X1, X0}
// SHIFT | arithmetic right shift of {A, X}, capture shifted-out bit
// DONE  | one-cycle completion pulse, product valid on result bus
module booth_controller
    import booth_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic X1,
    input  logic X0,
    output logic busy,
    output logic done,
    output logic ld_X,
    output logic ld_Y,
    output logic init_A,
    output logic init_ff,
    output logic ld_A,
    output logic add,
    output logic sub,
    output logic shift_a,
    output logic shift_x,
    output logic ld_ff
);

    state_t state;
    state_t state_next;
    logic   step_clear;
    logic   step_inc;
    logic   step_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    booth_step_counter #(.N(N)) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (step_clear),
        .inc   (step_inc),
        .last  (step_last)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        ld_X       = 1'b0;
        ld_Y       = 1'b0;
        init_A     = 1'b0;
        init_ff    = 1'b0;
        ld_A       = 1'b0;
        add        = 1'b0;
        sub        = 1'b0;
        shift_a    = 1'b0;
        shift_x    = 1'b0;
        ld_ff      = 1'b0;
        step_clear = 1'b0;
        step_inc   = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ld_X       = 1'b1;
                ld_Y       = 1'b1;
                ld_A       = 1'b1;
                init_A     = 1'b1;
                ld_ff      = 1'b1;
                init_ff    = 1'b1;
                step_clear = 1'b1;
                state_next = EVAL;
            end
            EVAL: begin
                // Pairs 00 and 11 leave the accumulator untouched.
                if ({X1, X0} == BOOTH_SUB) begin
                    sub  = 1'b1;
                    ld_A = 1'b1;
                end else if ({X1, X0} == BOOTH_ADD) begin
                    add  = 1'b1;
                    ld_A = 1'b1;
                end
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_a = 1'b1;
                shift_x = 1'b1;
                ld_ff   = 1'b1;
                if (step_last) begin
                    state_next = DONE;
                end else begin
                    step_inc   = 1'b1;
                    state_next = EVAL;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
